// File: rtl/video_timing_gen.sv
// Raster timing generator: H/V counters, blanking, sync, frame strobe and
// blank-gated registered RGB, all advancing on the pixel clock enable.
// Ports: i_clk, i_reset (async, active-high), i_pce (pixel enable),
//   i_irgb (core colour), i_hshift/i_vshift (signed sync shift, only with
//   `VTG_SHIFT_EN), o_hpos/o_vpos (counters), o_hblk/o_vblk (blanking),
//   o_hsyn/o_vsyn (sync, SYNC_POL polarity), o_fstart (at 0,0),
//   o_orgb (gated colour, 1 PCE late), o_ode (display enable for o_orgb).
// Optional feature macro: VTG_SHIFT_EN (runtime sync displacement).
module video_timing_gen #(
  parameter int CNT_W    = 9,
  parameter int RGB_W    = 12,
  parameter int H_ACTIVE = 288,
  parameter int H_FP     = 23,
  parameter int H_SYNC   = 31,
  parameter int H_TOTAL  = 384,
  parameter int V_ACTIVE = 224,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 7,
  parameter int V_TOTAL  = 263,
  parameter int SYNC_POL = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_pce,
  input  logic [RGB_W-1:0] i_irgb,
`ifdef VTG_SHIFT_EN
  input  logic [3:0]       i_hshift,
  input  logic [3:0]       i_vshift,
`endif
  output logic [CNT_W-1:0] o_hpos,
  output logic [CNT_W-1:0] o_vpos,
  output logic             o_hblk,
  output logic             o_vblk,
  output logic             o_hsyn,
  output logic             o_vsyn,
  output logic             o_fstart,
  output logic [RGB_W-1:0] o_orgb,
  output logic             o_ode
);

  if (H_ACTIVE + H_FP + H_SYNC > H_TOTAL) begin : g_chk_h
    $error("video_timing_gen: horizontal timing exceeds H_TOTAL");
  end
  if (V_ACTIVE + V_FP + V_SYNC > V_TOTAL) begin : g_chk_v
    $error("video_timing_gen: vertical timing exceeds V_TOTAL");
  end
  if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_chk_w
    $error("video_timing_gen: totals do not fit in CNT_W");
  end

  localparam int HS_NOM = H_ACTIVE + H_FP;
  localparam int HS_MAX = H_TOTAL - H_SYNC;
  localparam int VS_NOM = V_ACTIVE + V_FP;
  localparam int VS_MAX = V_TOTAL - V_SYNC;
  localparam logic SYN_OFF = (SYNC_POL == 0);

  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             r_hblk;
  logic             r_vblk;
  logic             r_hsyn;
  logic             r_vsyn;
  logic             r_fstart;
  logic [RGB_W-1:0] r_orgb;
  logic             r_ode;

  logic signed [3:0] w_hsh;
  logic signed [3:0] w_vsh;

  logic             w_h_last;
  logic             w_v_last;
  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;
  int               w_hs0;
  int               w_vs0;
  logic             w_hs_in;
  logic             w_vs_in;

`ifdef VTG_SHIFT_EN
  logic signed [3:0] r_hsh;
  logic signed [3:0] r_vsh;

  // Shift only latched when entering (0,0) so a frame never tears.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hsh <= '0;
      r_vsh <= '0;
    end else if (i_pce && w_h_last && w_v_last) begin
      r_hsh <= $signed(i_hshift);
      r_vsh <= $signed(i_vshift);
    end
  end

  assign w_hsh = r_hsh;
  assign w_vsh = r_vsh;
`else
  assign w_hsh = 4'sd0;
  assign w_vsh = 4'sd0;
`endif

  assign w_h_last = (r_h == CNT_W'(H_TOTAL - 1));
  assign w_v_last = (r_v == CNT_W'(V_TOTAL - 1));

  always_comb begin
    w_h_nxt = r_h + 1'b1;
    w_v_nxt = r_v;
    if (w_h_last) begin
      w_h_nxt = '0;
      w_v_nxt = w_v_last ? '0 : r_v + 1'b1;
    end
  end

  // Sync start points with displacement, held inside the blanking region.
  always_comb begin
    w_hs0 = HS_NOM + int'(w_hsh);
    if (w_hs0 < H_ACTIVE) w_hs0 = H_ACTIVE;
    if (w_hs0 > HS_MAX)   w_hs0 = HS_MAX;
    w_vs0 = VS_NOM + int'(w_vsh);
    if (w_vs0 < V_ACTIVE) w_vs0 = V_ACTIVE;
    if (w_vs0 > VS_MAX)   w_vs0 = VS_MAX;
  end

  assign w_hs_in = (int'(w_h_nxt) >= w_hs0) &&
                   (int'(w_h_nxt) <  w_hs0 + H_SYNC);
  assign w_vs_in = (int'(w_v_nxt) >= w_vs0) &&
                   (int'(w_v_nxt) <  w_vs0 + V_SYNC);

  // Flags decoded from the next count so they line up with o_hpos/o_vpos;
  // colour uses the current flags, giving one PCE of latency.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_h      <= '0;
      r_v      <= '0;
      r_hblk   <= 1'b0;
      r_vblk   <= 1'b0;
      r_hsyn   <= SYN_OFF;
      r_vsyn   <= SYN_OFF;
      r_fstart <= 1'b1;
      r_orgb   <= '0;
      r_ode    <= 1'b0;
    end else if (i_pce) begin
      r_h      <= w_h_nxt;
      r_v      <= w_v_nxt;
      r_hblk   <= (w_h_nxt >= CNT_W'(H_ACTIVE));
      r_vblk   <= (w_v_nxt >= CNT_W'(V_ACTIVE));
      r_hsyn   <= w_hs_in ^ SYN_OFF;
      r_vsyn   <= w_vs_in ^ SYN_OFF;
      r_fstart <= (w_h_nxt == '0) && (w_v_nxt == '0);
      r_orgb   <= (r_hblk | r_vblk) ? '0 : i_irgb;
      r_ode    <= ~(r_hblk | r_vblk);
    end
  end

  assign o_hpos   = r_h;
  assign o_vpos   = r_v;
  assign o_hblk   = r_hblk;
  assign o_vblk   = r_vblk;
  assign o_hsyn   = r_hsyn;
  assign o_vsyn   = r_vsyn;
  assign o_fstart = r_fstart;
  assign o_orgb   = r_orgb;
  assign o_ode    = r_ode;

endmodule
